seg7_scan_4dig: RTL and testbench

Time-multiplexed driver for the board's four 7-segment digits. It sits directly downstream of the adder/subtractor top level. It consumes the 16-bit packed nibble bus (four hex digits) and the per-digit negative flags, and drives the 12-bit DISP bus (anodes plus segments). It latches its inputs once per scan frame, so the display never tears, and it adds per-digit blanking, blinking and anode dead-time.

---
 rtl/seg7_scan_4dig.sv | 164 ++++++++++++++++
 tb/tb_seg7_scan_4dig.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_4dig.sv
// seg7_scan_4dig: time-multiplexed driver for four 7-segment digits.
// Snapshots the nibble bus and per-digit controls once per scan frame, then
// scans digit 3 down to digit 0. Each slot opens with an all-anodes-off
// dead time to suppress ghosting.
//
// Ports:
//   CLK        system clock
//   RST_N      asynchronous active-low reset
//   data       four hex digits, [15:12] = digit 3 ... [3:0] = digit 0
//   neg        per-digit decimal-point request
//   blank      per-digit force-dark
//   blink      per-digit blink enable (dark while the blink phase is off)
//   DISP       [11:8] anodes (active-low), [7] DP, [6:0] g..a (active-low)
//   frame_tick one-cycle pulse aligned with the input snapshot
module seg7_scan_4dig #(
    parameter int unsigned INTERVAL     = 50000,
    parameter int unsigned DEAD         = 64,
    parameter int unsigned BLINK_FRAMES = 250
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] data,
    input  logic [3:0]  neg,
    input  logic [3:0]  blank,
    input  logic [3:0]  blink,
    output logic [11:0] DISP,
    output logic        frame_tick
);

    localparam int unsigned CNT_W  = (INTERVAL > 2) ? $clog2(INTERVAL) : 1;
    localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       data_s_q, data_s_d;
    logic [3:0]        neg_s_q, neg_s_d;
    logic [3:0]        blank_s_q, blank_s_d;
    logic [3:0]        blink_s_q, blink_s_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              bph_q, bph_d;
    logic              first_q, first_d;
    logic [11:0]       disp_q, disp_d;
    logic              frame_tick_q, frame_tick_d;

    logic              frame_start;
    logic              slot_wrap;
    logic              lit;
    logic [3:0]        nib;

    // Hex nibble to active-low gfedcba pattern.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Next-state: slot/digit counters, frame snapshot, blink timing, DISP.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        data_s_d     = data_s_q;
        neg_s_d      = neg_s_q;
        blank_s_d    = blank_s_q;
        blink_s_d    = blink_s_q;
        fcnt_d       = fcnt_q;
        bph_d        = bph_q;
        first_d      = first_q;
        disp_d       = 12'hFFF;
        lit          = 1'b0;
        nib          = 4'h0;

        frame_start  = (cnt_q == '0) && (idx_q == 2'd3);
        slot_wrap    = (cnt_q == CNT_W'(INTERVAL - 1));
        frame_tick_d = frame_start;

        if (slot_wrap) begin
            cnt_d = '0;
            idx_d = idx_q - 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (frame_start) begin
            data_s_d  = data;
            neg_s_d   = neg;
            blank_s_d = blank;
            blink_s_d = blink;
            first_d   = 1'b0;
            // The capture right after reset release starts blink timing at zero.
            if (!first_q) begin
                if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
                    fcnt_d = '0;
                    bph_d  = ~bph_q;
                end else begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
            end
        end

        // Uses the values being loaded this cycle so a zero dead time still
        // shows the new frame in the very first slot.
        lit = (cnt_q >= CNT_W'(DEAD)) && !blank_s_d[idx_q]
              && !(blink_s_d[idx_q] && bph_d);
        nib = data_s_d[{idx_q, 2'b00} +: 4];

        if (lit) begin
            disp_d[11:8] = ~(4'b0001 << idx_q);
            disp_d[7]    = ~neg_s_d[idx_q];
            disp_d[6:0]  = seg_decode(nib);
        end
    end

    // State registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q        <= '0;
            idx_q        <= 2'd3;
            data_s_q     <= 16'h0000;
            neg_s_q      <= 4'h0;
            blank_s_q    <= 4'hF;
            blink_s_q    <= 4'h0;
            fcnt_q       <= '0;
            bph_q        <= 1'b0;
            first_q      <= 1'b1;
            disp_q       <= 12'hFFF;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            data_s_q     <= data_s_d;
            neg_s_q      <= neg_s_d;
            blank_s_q    <= blank_s_d;
            blink_s_q    <= blink_s_d;
            fcnt_q       <= fcnt_d;
            bph_q        <= bph_d;
            first_q      <= first_d;
            disp_q       <= disp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign DISP       = disp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_4dig.sv
// Scoreboard bench for seg7_scan_4dig (INTERVAL=4, DEAD=1, BLINK_FRAMES=2).
// Stimulus pushes each frame's four expected digit words; the monitor pops one
// per frame_tick and checks all 16 DISP samples of that frame.
module tb_seg7_scan_4dig;

    localparam int unsigned INTERVAL     = 4;
    localparam int unsigned DEAD         = 1;
    localparam int unsigned BLINK_FRAMES = 2;
    localparam int          NFR          = 10;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] data;
    logic [3:0]  neg;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic [11:0] DISP;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    logic [47:0] exp_q[$];

    // Per-frame inputs and hand-computed expected words {digit3,2,1,0}.
    logic [15:0] t_data  [NFR] = '{16'h12AF, 16'h0000, 16'h0003, 16'h0003, 16'h0000,
                                   16'h0000, 16'h0000, 16'h0000, 16'hE4B7, 16'h9C5D};
    logic [3:0]  t_neg   [NFR] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA};
    logic [3:0]  t_blank [NFR] = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0]  t_blink [NFR] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4};
    logic [47:0] t_exp   [NFR] = '{
        {12'h7F9, 12'hBA4, 12'hD88, 12'hE8E},
        {12'h7C0, 12'hBC0, 12'hDC0, 12'hEC0},
        {12'h7C0, 12'hBC0, 12'hDC0, 12'hE30},
        {12'hFFF, 12'hBC0, 12'hDC0, 12'hE30},
        {12'h7C0, 12'hBC0, 12'hDC0, 12'hEC0},
        {12'h7C0, 12'hBC0, 12'hDC0, 12'hEC0},
        {12'h7C0, 12'hFFF, 12'hDC0, 12'hEC0},
        {12'h7C0, 12'hFFF, 12'hDC0, 12'hEC0},
        {12'h786, 12'hB99, 12'hD83, 12'hEF8},
        {12'h710, 12'hBC6, 12'hD12, 12'hEA1}
    };

    seg7_scan_4dig #(
        .INTERVAL    (INTERVAL),
        .DEAD        (DEAD),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .data      (data),
        .neg       (neg),
        .blank     (blank),
        .blink     (blink),
        .DISP      (DISP),
        .frame_tick(frame_tick)
    );

    always #5 CLK = ~CLK;

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input int n);
        data  = t_data[n];
        neg   = t_neg[n];
        blank = t_blank[n];
        blink = t_blink[n];
    endtask

    // Bounded wait for the next frame_tick, sampled on the falling edge.
    task automatic wait_tick();
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (frame_tick !== 1'b1 && k < 100);
        checks++;
        if (frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL wait_tick timeout actual=no_tick expected=tick");
            summary();
        end
    endtask

    // Scoreboard monitor: one expected frame per frame_tick.
    initial begin
        logic [47:0] f;
        logic [11:0] e;
        int          fno;
        fno = 0;
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1 && frame_tick === 1'b1 && exp_q.size() != 0) begin
                f = exp_q.pop_front();
                for (int i = 0; i < 16; i++) begin
                    if (i != 0) @(negedge CLK);
                    e = (i % 4 == 0) ? 12'hFFF : f[47 - 12 * (i / 4) -: 12];
                    check_val($sformatf("frame%0d_cyc%0d", fno, i), int'(DISP), int'(e));
                end
                fno++;
            end
        end
    end

    // frame_tick spacing must be 4*INTERVAL cycles once running.
    initial begin
        int since;
        since = -1;
        forever begin
            @(negedge CLK);
            if (RST_N !== 1'b1) begin
                since = -1;
            end else begin
                if (since >= 0) since++;
                if (frame_tick === 1'b1) begin
                    if (since >= 0) check_val("tick_period", since, 16);
                    since = 0;
                end
            end
        end
    end

    // At most one anode low in any cycle.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1)
                check_val("one_anode", int'($countones(~DISP[11:8]) <= 1), 1);
        end
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        summary();
    end

    initial begin
        RST_N = 1'b0;
        apply(0);
        repeat (3) @(negedge CLK);
        check_val("reset_disp", int'(DISP), 12'hFFF);
        check_val("reset_tick", int'(frame_tick), 0);
        exp_q.push_back(t_exp[0]);
        RST_N = 1'b1;

        // Inputs for the next frame change mid-frame (digit-1 slot).
        for (int n = 1; n < NFR; n++) begin
            wait_tick();
            repeat (9) @(negedge CLK);
            apply(n);
            exp_q.push_back(t_exp[n]);
        end

        wait_tick();
        wait_tick();
        repeat (10) @(negedge CLK);
        check_val("pre_reset_disp", int'(DISP), 12'hD12);
        #2;
        RST_N = 1'b0;
        #1;
        check_val("async_reset_disp", int'(DISP), 12'hFFF);
        check_val("async_reset_tick", int'(frame_tick), 0);
        apply(0);
        exp_q.push_back(t_exp[0]);
        repeat (3) @(negedge CLK);
        check_val("held_reset_disp", int'(DISP), 12'hFFF);
        RST_N = 1'b1;
        wait_tick();
        repeat (20) @(negedge CLK);
        check_val("queue_drained", exp_q.size(), 0);
        summary();
    end

endmodule
